// File: rtl/push_arb.sv
// Two-player pushbutton arbiter: synchronises both buttons, detects false starts
// outside the round window and decides the winner or a tie within a short tie window.
module push_arb #(
    parameter int unsigned TIE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    input  logic       arm,
    input  logic       clr,
    output logic       winrnd,
    output logic       right,
    output logic       tie,
    output logic [1:0] fstart,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StTieWin,
        StDecided,
        StLock
    } state_e;

    state_e state_q, state_d;

    // Bit 0 is the left button, bit 1 the right button throughout.
    logic [1:0] meta_q, sync_q, prev_q;
    logic [1:0] settle_q;
    logic [1:0] hold_q, hold_d;
    logic [1:0] mask_q, mask_d;
    logic [1:0] press;
    logic       settled;

    logic [7:0] cnt_q, cnt_d;
    logic       lead_q, lead_d;
    logic       win_q, win_d;
    logic       right_q, right_d;
    logic       tie_q, tie_d;
    logic       opp_press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q   <= 2'b00;
            sync_q   <= 2'b00;
            prev_q   <= 2'b00;
            settle_q <= 2'd0;
        end else begin
            meta_q <= {pbr, pbl};
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (settle_q != 2'd2) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    // A button held through reset stays blocked until the synchroniser has refilled and
    // shows it released; hold resets to 1 so such a press never reads as a fresh edge.
    assign settled = (settle_q == 2'd2);
    assign hold_d  = settled ? (hold_q & sync_q) : hold_q;

    // Buttons already down when the window opens stay masked until released.
    always_comb begin
        mask_d = mask_q & sync_q;
        if (state_q == StIdle && arm) begin
            mask_d = sync_q;
        end
    end

    assign press = sync_q & ~prev_q & ~hold_q & ~mask_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= 2'b11;
            mask_q <= 2'b00;
        end else begin
            hold_q <= hold_d;
            mask_q <= mask_d;
        end
    end

    assign opp_press = lead_q ? press[0] : press[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lead_d  = lead_q;
        win_d   = 1'b0;
        right_d = right_q;
        tie_d   = tie_q;
        fstart  = 2'b00;
        case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d = StArmed;
                end else begin
                    fstart = press;
                end
            end
            StArmed: begin
                if (press == 2'b11) begin
                    state_d = StDecided;
                    win_d   = 1'b1;
                    right_d = 1'b0;
                    tie_d   = 1'b1;
                end else if (press != 2'b00) begin
                    state_d = StTieWin;
                    lead_d  = press[1];
                    cnt_d   = 8'(TIE_CYC - 1);
                end else if (!arm) begin
                    state_d = StIdle;
                end
            end
            StTieWin: begin
                if (opp_press) begin
                    state_d = StDecided;
                    win_d   = 1'b1;
                    right_d = 1'b0;
                    tie_d   = 1'b1;
                end else if (cnt_q == 8'd0) begin
                    state_d = StDecided;
                    win_d   = 1'b1;
                    right_d = lead_q;
                    tie_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StDecided: begin
                if (clr) begin
                    state_d = StLock;
                    right_d = 1'b0;
                    tie_d   = 1'b0;
                end
            end
            StLock: begin
                if (sync_q == 2'b00 && !arm) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            lead_q  <= 1'b0;
            win_q   <= 1'b0;
            right_q <= 1'b0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lead_q  <= lead_d;
            win_q   <= win_d;
            right_q <= right_d;
            tie_q   <= tie_d;
        end
    end

    assign winrnd = win_q;
    assign right  = right_q;
    assign tie    = tie_q;
    assign busy   = (state_q != StIdle);

endmodule
